cd_bound_finder: RTL and testbench

//  Finds the connected run of 1s in a 512-bit binary row that contains a seed pixel.

---
 rtl/cdf_pkg.sv | 62 ++++++
 rtl/cd_edge_scan.sv | 24 ++
 rtl/cd_bound_finder.sv | 204 ++++++++++++++++++++
 tb/tb_cd_bound_finder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdf_pkg.sv
// Shared constants, FSM encoding and lane-gather helpers for cd_bound_finder.
// Build option CD_BOUND_FINDER_PARALLEL_EN selects the merged left/right scan.
package cdf_pkg;

  localparam int ROW_W  = 512;
  localparam int IDX_W  = 9;
  localparam int SCAN_W = 16;
  localparam int OFF_W  = $clog2(SCAN_W);
  localparam int PTR_W  = IDX_W + 1;

  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(ROW_W - 1);
  localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(SCAN_W);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(ROW_W - 1);

  // ST_SCAN is only reachable in the parallel build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN_L = 3'd1,
    ST_SCAN_R = 3'd2,
    ST_DONE   = 3'd3,
    ST_SCAN   = 3'd4
  } state_t;

  // Lane k of a left chunk is bit ptr+1+k; lanes past bit 511 are invalid.
  function automatic logic [SCAN_W-1:0] left_valid(input logic [PTR_W-1:0] ptr);
    logic [SCAN_W-1:0] v;
    for (int k = 0; k < SCAN_W; k++)
      v[k] = (ptr + PTR_W'(k + 1)) <= PTR_MAX;
    return v;
  endfunction

  function automatic logic [SCAN_W-1:0] left_bits(input logic [ROW_W-1:0] row,
                                                  input logic [PTR_W-1:0] ptr);
    logic [SCAN_W-1:0] b;
    logic [PTR_W-1:0]  idx;
    for (int k = 0; k < SCAN_W; k++) begin
      idx  = ptr + PTR_W'(k + 1);
      b[k] = (idx <= PTR_MAX) ? row[idx[IDX_W-1:0]] : 1'b0;
    end
    return b;
  endfunction

  // Lane k of a right chunk is bit ptr-1-k; lanes below bit 0 are invalid.
  function automatic logic [SCAN_W-1:0] right_valid(input logic [PTR_W-1:0] ptr);
    logic [SCAN_W-1:0] v;
    for (int k = 0; k < SCAN_W; k++)
      v[k] = ptr > PTR_W'(k);
    return v;
  endfunction

  function automatic logic [SCAN_W-1:0] right_bits(input logic [ROW_W-1:0] row,
                                                   input logic [PTR_W-1:0] ptr);
    logic [SCAN_W-1:0] b;
    logic [PTR_W-1:0]  idx;
    for (int k = 0; k < SCAN_W; k++) begin
      idx  = ptr - PTR_W'(k + 1);
      b[k] = (ptr > PTR_W'(k)) ? row[idx[IDX_W-1:0]] : 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/cd_edge_scan.sv
// Combinational edge finder: reports the valid lane holding a 0 that is closest
// to the seed (lane 0 is nearest).
module cd_edge_scan
  import cdf_pkg::*;
(
  input  logic [SCAN_W-1:0] chunk,
  input  logic [SCAN_W-1:0] lanes,
  output logic              found,
  output logic [OFF_W-1:0]  offset
);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    // Descending walk so the lowest matching lane is the one that sticks.
    for (int k = SCAN_W - 1; k >= 0; k--) begin
      if (lanes[k] && !chunk[k]) begin
        found  = 1'b1;
        offset = OFF_W'(k);
      end
    end
  end

endmodule

// File: rtl/cd_bound_finder.sv
// Finds the run of 1s containing the seed pixel and reports left/right exclusion
// counts. Define CD_BOUND_FINDER_PARALLEL_EN to scan both directions at once.
module cd_bound_finder
  import cdf_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_row,
  input  logic [IDX_W-1:0] i_seed,
  output logic             o_busy,
  output logic             o_trig,
  output logic [IDX_W-1:0] o_bound_left,
  output logic [IDX_W-1:0] o_bound_right,
  output logic             o_seed_miss,
  output logic [2:0]       o_dbg_state
);

  // Handshake: i_start is accepted only in IDLE (o_busy low, not DONE); o_trig is a
  // single-cycle pulse in DONE, and bounds/miss are valid from that cycle until the
  // next accepted start. There is no backpressure and no queueing of starts.

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_q;
  logic [PTR_W-1:0] ptr_l, ptr_r;
  logic [IDX_W-1:0] hi_q;
  logic             seed_bit;

  logic             found_l, found_r;
  logic [OFF_W-1:0] off_l, off_r;
  logic             end_l, end_r;
  logic [IDX_W-1:0] hi_nxt, lo_nxt;

  assign seed_bit = i_row[i_seed];

`ifdef CD_BOUND_FINDER_PARALLEL_EN
  localparam state_t SCAN_FIRST = ST_SCAN;

  logic             l_done, r_done;
  logic [IDX_W-1:0] lo_q;
  logic             fin_l, fin_r;
  logic [IDX_W-1:0] hi_fin, lo_fin;

  cd_edge_scan u_scan_l (
    .chunk  (left_bits(row_q, ptr_l)),
    .lanes  (left_valid(ptr_l)),
    .found  (found_l),
    .offset (off_l)
  );

  cd_edge_scan u_scan_r (
    .chunk  (right_bits(row_q, ptr_r)),
    .lanes  (right_valid(ptr_r)),
    .found  (found_r),
    .offset (off_r)
  );

  always_comb begin
    fin_l  = l_done || end_l;
    fin_r  = r_done || end_r;
    hi_fin = l_done ? hi_q : hi_nxt;
    lo_fin = r_done ? lo_q : lo_nxt;
  end
`else
  localparam state_t SCAN_FIRST = ST_SCAN_L;

  logic [SCAN_W-1:0] chunk_s, lanes_s;
  logic              found_s;
  logic [OFF_W-1:0]  off_s;

  // One scan unit serves both directions; the state picks which window it sees.
  always_comb begin
    if (state == ST_SCAN_R) begin
      chunk_s = right_bits(row_q, ptr_r);
      lanes_s = right_valid(ptr_r);
    end else begin
      chunk_s = left_bits(row_q, ptr_l);
      lanes_s = left_valid(ptr_l);
    end
  end

  cd_edge_scan u_scan (
    .chunk  (chunk_s),
    .lanes  (lanes_s),
    .found  (found_s),
    .offset (off_s)
  );

  always_comb begin
    found_l = found_s;
    off_l   = off_s;
    found_r = found_s;
    off_r   = off_s;
  end
`endif

  // A side ends on the first 0 or when the chunk reaches the row edge.
  always_comb begin
    end_l  = found_l || ((ptr_l + PTR_STEP) >= PTR_MAX);
    end_r  = found_r || (ptr_r <= PTR_STEP);
    hi_nxt = found_l ? (ptr_l[IDX_W-1:0] + IDX_W'(off_l)) : IDX_MAX;
    lo_nxt = found_r ? (ptr_r[IDX_W-1:0] - IDX_W'(off_r)) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = seed_bit ? SCAN_FIRST : ST_DONE;
`ifdef CD_BOUND_FINDER_PARALLEL_EN
      ST_SCAN: if (fin_l && fin_r) state_nxt = ST_DONE;
`else
      ST_SCAN_L: if (end_l) state_nxt = ST_SCAN_R;
      ST_SCAN_R: if (end_r) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state != ST_IDLE);
    o_trig      = (state == ST_DONE);
    o_dbg_state = state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q         <= '0;
      ptr_l         <= '0;
      ptr_r         <= '0;
      hi_q          <= '0;
      o_bound_left  <= '0;
      o_bound_right <= '0;
      o_seed_miss   <= 1'b0;
`ifdef CD_BOUND_FINDER_PARALLEL_EN
      lo_q          <= '0;
      l_done        <= 1'b0;
      r_done        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            row_q <= i_row;
            ptr_l <= {1'b0, i_seed};
            ptr_r <= {1'b0, i_seed};
`ifdef CD_BOUND_FINDER_PARALLEL_EN
            l_done <= 1'b0;
            r_done <= 1'b0;
`endif
            // A miss is resolved immediately: full exclusion on both masks.
            o_bound_left  <= seed_bit ? '0 : IDX_MAX;
            o_bound_right <= seed_bit ? '0 : IDX_W'(1);
            o_seed_miss   <= !seed_bit;
          end
        end
`ifdef CD_BOUND_FINDER_PARALLEL_EN
        ST_SCAN: begin
          if (!l_done) begin
            if (end_l) begin
              hi_q   <= hi_nxt;
              l_done <= 1'b1;
            end else begin
              ptr_l <= ptr_l + PTR_STEP;
            end
          end
          if (!r_done) begin
            if (end_r) begin
              lo_q   <= lo_nxt;
              r_done <= 1'b1;
            end else begin
              ptr_r <= ptr_r - PTR_STEP;
            end
          end
          if (fin_l && fin_r) begin
            o_bound_left  <= IDX_MAX - hi_fin;
            o_bound_right <= lo_fin;
          end
        end
`else
        ST_SCAN_L: begin
          if (end_l) hi_q  <= hi_nxt;
          else       ptr_l <= ptr_l + PTR_STEP;
        end
        ST_SCAN_R: begin
          if (end_r) begin
            o_bound_left  <= IDX_MAX - hi_q;
            o_bound_right <= lo_nxt;
          end else begin
            ptr_r <= ptr_r - PTR_STEP;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_bound_finder.sv
// Bench for cd_bound_finder: directed vectors with literal expectations, random rows,
// and a per-cycle compare against a bit-walking reference model.
module tb_cd_bound_finder;

`ifdef CD_BOUND_FINDER_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst, i_start;
  logic [511:0] i_row;
  logic [8:0]   i_seed;
  logic         o_busy, o_trig, o_seed_miss;
  logic [8:0]   o_bound_left, o_bound_right;
  logic [2:0]   o_dbg_state;

  cd_bound_finder dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_row(i_row), .i_seed(i_seed),
    .o_busy(o_busy), .o_trig(o_trig), .o_bound_left(o_bound_left),
    .o_bound_right(o_bound_right), .o_seed_miss(o_seed_miss), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [18:0] exp_q[$];     // {miss, left, right}
  bit          chk_en = 1'b0;
  bit          active = 1'b0;
  int          s_cyc = 0;
  int          lat = 0;
  logic [18:0] hold;
  bit          hold_valid = 1'b0;
  bit          exp_trig, exp_busy;
  logic [18:0] got;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: walk bit by bit to the run edges, then count the chunks needed.
  function automatic void model(input logic [511:0] row, input int seed,
                                output int left, output int right,
                                output int mlat, output bit miss);
    int hi, lo, lc, rc;
    if (!row[seed]) begin
      miss = 1'b1; left = 511; right = 1; mlat = 1;
      return;
    end
    miss = 1'b0;
    hi = seed;
    while (hi < 511 && row[hi+1]) hi++;
    lo = seed;
    while (lo > 0 && row[lo-1]) lo--;
    if (hi < 511) lc = (hi - seed) / 16 + 1;
    else          lc = ((511 - seed + 15) / 16 > 1) ? (511 - seed + 15) / 16 : 1;
    if (lo > 0)   rc = (seed - lo) / 16 + 1;
    else          rc = ((seed + 15) / 16 > 1) ? (seed + 15) / 16 : 1;
    left  = 511 - hi;
    right = lo;
    mlat  = PAR ? ((lc > rc ? lc : rc) + 1) : (lc + rc + 1);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      exp_trig = active && (cyc == s_cyc + lat);
      exp_busy = active && (cyc >= s_cyc + 1) && (cyc <= s_cyc + lat);
      check("trig", o_trig, exp_trig);
      check("busy", o_busy, exp_busy);
      if (exp_trig) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 0, 1);
        end else begin
          hold = exp_q.pop_front();
          hold_valid = 1'b1;
        end
      end
      if (hold_valid && !(exp_busy && !exp_trig)) begin
        got = {o_seed_miss, o_bound_left, o_bound_right};
        check("bound_left", got[17:9], hold[17:9]);
        check("bound_right", got[8:0], hold[8:0]);
        check("seed_miss", got[18], hold[18]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_pulse(input logic [511:0] row, input int seed);
    @(negedge clk);
    i_row = row; i_seed = 9'(seed); i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic run(input logic [511:0] row, input int seed);
    int ml, mr, mlat, s;
    bit mm;
    model(row, seed, ml, mr, mlat, mm);
    @(negedge clk);
    i_row = row; i_seed = 9'(seed); i_start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 i_start = 1'b0;
    s_cyc = s; lat = mlat; active = 1'b1;
    exp_q.push_back({mm, 9'(ml), 9'(mr)});
  endtask

  task automatic wait_trig(output int got_lat);
    got_lat = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (o_trig) begin
        got_lat = cyc - s_cyc;
        break;
      end
    end
    if (got_lat < 0) begin
      check("trig_timeout", 0, 1);
      active = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic lit(input string name, input int ll, input int rr, input int mm,
                     input int lt_seq, input int lt_par, input int got_lat);
    check({name, "_left"}, o_bound_left, ll);
    check({name, "_right"}, o_bound_right, rr);
    check({name, "_miss"}, o_seed_miss, mm);
    check({name, "_lat"}, got_lat, PAR ? lt_par : lt_seq);
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] r;
  int           gl;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_row = '0; i_seed = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    hold = '0; hold_valid = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    check("reset_state", o_dbg_state, 0);
    check("reset_outputs", {o_busy, o_trig, o_seed_miss, o_bound_left, o_bound_right}, 0);

    // 1: all ones, seed 100
    run('1, 100); wait_trig(gl); lit("all_ones_s100", 0, 0, 0, 34, 27, gl);

    // 2: run [300:200]
    r = '0;
    for (int i = 200; i <= 300; i++) r[i] = 1'b1;
    run(r, 250); wait_trig(gl); lit("run_300_200", 211, 200, 0, 9, 5, gl);

    // 3: seed miss
    r = '1; r[37] = 1'b0;
    run(r, 37); wait_trig(gl); lit("miss_37", 511, 1, 1, 1, 1, gl);
    repeat (3) @(negedge clk);

    // 4: seeds at both row edges
    run('1, 511); wait_trig(gl); lit("all_ones_s511", 0, 0, 0, 34, 33, gl);
    run('1, 0);   wait_trig(gl); lit("all_ones_s0", 0, 0, 0, 34, 33, gl);

    // 6: isolated 1 at bit 64
    r = '0; r[64] = 1'b1;
    run(r, 64); wait_trig(gl); lit("isolated_64", 447, 64, 0, 3, 2, gl);

    // 5a: start while busy and start during DONE are both ignored
    run('1, 100);
    repeat (4) @(negedge clk);
    start_pulse('0, 5);
    wait_trig(gl);
    lit("ignored_start", 0, 0, 0, 34, 27, gl);
    i_row = '0; i_seed = 9'd3; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(negedge clk);

    // 5b: reset mid-scan aborts without a trig; outputs return to 0
    r = '0;
    for (int i = 200; i <= 300; i++) r[i] = 1'b1;
    run(r, 250); wait_trig(gl);          // leave nonzero bounds behind
    run('1, 100);
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    i_rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 i_rst = 1'b0;
    active = 1'b0; exp_q.delete(); hold = '0; hold_valid = 1'b1; chk_en = 1'b1;
    repeat (40) @(negedge clk);
    run(r, 250); wait_trig(gl); lit("after_reset", 211, 200, 0, 9, 5, gl);

    // random rows: sparse zeros give long runs
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 512; i++) r[i] = ($urandom_range(0, 31) != 0);
      run(r, (t % 6 == 0) ? ((t % 12 == 0) ? 0 : 511) : int'($urandom_range(0, 511)));
      wait_trig(gl);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
